// File: rtl/implication_queue.sv
// implication_queue
// Collects per-lane implications from the clause evaluators during BCP.
// Each accepted batch is deduplicated, checked for opposite-polarity
// conflicts and compacted into a circular FIFO. The FIFO hands one
// implication per cycle to the trail stage over valid/ready.
//
// Optional feature (macro IMPLQ_QUEUE_CHECK_EN): incoming lanes are also
// matched against every resident FIFO entry, including one being popped in
// the same cycle. A match with the same value drops the lane, and a match
// with the opposite value raises a conflict.
//
// Ports:
//   clock, reset_n   rising-edge clock, asynchronous active-low reset
//   flush            synchronous clear of FIFO and conflict (backtrack)
//   in_valid/in_var/in_val   per-lane implication batch
//   in_ready         batch acceptance (registered state/count only)
//   out_valid/out_var/out_val/out_ready   head handshake
//   conflict, conflict_var   sticky conflict flag and offending variable
//   count, empty     FIFO occupancy
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif

module implication_queue #(
  parameter int NUM_EVAL = 4,
  parameter int DEPTH    = 16
) (
  input  logic                                     clock,
  input  logic                                     reset_n,
  input  logic                                     flush,
  input  logic [NUM_EVAL-1:0]                      in_valid,
  input  logic [NUM_EVAL-1:0][`MAX_VARS_BITS-1:0]  in_var,
  input  logic [NUM_EVAL-1:0]                      in_val,
  output logic                                     in_ready,
  output logic                                     out_valid,
  output logic [`MAX_VARS_BITS-1:0]                out_var,
  output logic                                     out_val,
  input  logic                                     out_ready,
  output logic                                     conflict,
  output logic [`MAX_VARS_BITS-1:0]                conflict_var,
  output logic [$clog2(DEPTH+1)-1:0]               count,
  output logic                                     empty
);

  localparam int VW = `MAX_VARS_BITS;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_CONFLICT = 1'b1;

  logic [0:0]    state;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [VW-1:0] mem_var [DEPTH];
  logic          mem_val [DEPTH];
  logic [VW-1:0] hold_var;
  logic          hold_val;

  logic [CW-1:0]       free;
  logic                accept;
  logic                push;
  logic                pop;
  logic [NUM_EVAL-1:0] lane_dup;
  logic [NUM_EVAL-1:0] lane_conf;
  logic [NUM_EVAL-1:0] keep;
  logic                batch_conf;
  logic [VW-1:0]       conf_var;
  logic [CW-1:0]       n_surv;
  logic [AW-1:0]       wr_addr [NUM_EVAL];

  // Handshake: in_ready looks only at registered state/count, so a pop in
  // the same cycle never opens room for a batch.
  assign free      = CW'(DEPTH) - count;
  assign in_ready  = (state == ST_RUN) && (free >= CW'(NUM_EVAL));
  assign empty     = (count == '0);
  assign out_valid = (state == ST_RUN) && !empty;
  assign out_var   = empty ? hold_var : mem_var[head];
  assign out_val   = empty ? hold_val : mem_val[head];
  assign accept    = in_ready && (|in_valid) && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign push      = accept && !batch_conf;

  // Batch evaluation: a lane is compared against every lower valid lane
  // (and, with the queue check, every resident entry).
  always_comb begin
    lane_dup  = '0;
    lane_conf = '0;
    for (int j = 0; j < NUM_EVAL; j++) begin
      if (in_valid[j]) begin
        for (int i = 0; i < NUM_EVAL; i++) begin
          if (i < j && in_valid[i] && in_var[i] == in_var[j]) begin
            if (in_val[i] == in_val[j]) lane_dup[j]  = 1'b1;
            else                        lane_conf[j] = 1'b1;
          end
        end
`ifdef IMPLQ_QUEUE_CHECK_EN
        for (int k = 0; k < DEPTH; k++) begin
          // Slot k is resident when its distance from head is below count.
          if ((CW'(AW'(AW'(k) - head)) < count) && mem_var[k] == in_var[j]) begin
            if (mem_val[k] == in_val[j]) lane_dup[j]  = 1'b1;
            else                         lane_conf[j] = 1'b1;
          end
        end
`endif
      end
    end
    keep       = in_valid & ~lane_dup;
    batch_conf = |lane_conf;
    // Descending scan so the lowest conflicting lane wins.
    conf_var = '0;
    for (int j = NUM_EVAL-1; j >= 0; j--) begin
      if (lane_conf[j]) conf_var = in_var[j];
    end
  end

  // Compaction: each surviving lane lands at tail plus the number of
  // survivors below it.
  always_comb begin
    n_surv = '0;
    for (int j = 0; j < NUM_EVAL; j++) begin
      wr_addr[j] = tail + AW'(n_surv);
      if (keep[j]) n_surv = n_surv + CW'(1);
    end
  end

  // Storage: payload only, no reset needed since slots are read only once
  // they hold a written entry.
  always_ff @(posedge clock) begin
    if (push) begin
      for (int j = 0; j < NUM_EVAL; j++) begin
        if (keep[j]) begin
          mem_var[wr_addr[j]] <= in_var[j];
          mem_val[wr_addr[j]] <= in_val[j];
        end
      end
    end
  end

  // Control: pointers, occupancy, conflict state and the output hold
  // registers that keep out_var/out_val stable while empty.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_RUN;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      conflict     <= 1'b0;
      conflict_var <= '0;
      hold_var     <= '0;
      hold_val     <= 1'b0;
    end else begin
      hold_var <= out_var;
      hold_val <= out_val;
      if (flush) begin
        state        <= ST_RUN;
        head         <= '0;
        tail         <= '0;
        count        <= '0;
        conflict     <= 1'b0;
        conflict_var <= '0;
      end else begin
        if (accept && batch_conf) begin
          state        <= ST_CONFLICT;
          conflict     <= 1'b1;
          conflict_var <= conf_var;
        end
        if (push) tail <= tail + AW'(n_surv);
        if (pop)  head <= head + AW'(1);
        count <= count + (push ? n_surv : CW'(0)) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_implication_queue.sv
// Testbench for implication_queue: randomized and directed batches checked
// against a queue-based reference model by a separate monitor process.
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif

module tb_implication_queue;

  localparam int NE    = 4;
  localparam int DEPTH = 16;
  localparam int VW    = `MAX_VARS_BITS;
  localparam int CW    = $clog2(DEPTH+1);

  typedef logic [NE-1:0][VW-1:0] lanes_t;
  typedef struct packed {
    logic [VW-1:0] v;
    logic          b;
  } impl_t;

  logic                  clock = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  flush = 1'b0;
  logic [NE-1:0]         in_valid = '0;
  lanes_t                in_var = '0;
  logic [NE-1:0]         in_val = '0;
  logic                  in_ready;
  logic                  out_valid;
  logic [VW-1:0]         out_var;
  logic                  out_val;
  logic                  out_ready = 1'b0;
  logic                  conflict;
  logic [VW-1:0]         conflict_var;
  logic [CW-1:0]         count;
  logic                  empty;

  implication_queue #(.NUM_EVAL(NE), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_var(in_var), .in_val(in_val), .in_ready(in_ready),
    .out_valid(out_valid), .out_var(out_var), .out_val(out_val), .out_ready(out_ready),
    .conflict(conflict), .conflict_var(conflict_var), .count(count), .empty(empty)
  );

  always #5 clock = ~clock;

  // Reference model state: mq is the expected FIFO content, head first.
  impl_t         mq[$];
  bit            m_conf;
  logic [VW-1:0] m_cvar;
  logic [VW-1:0] last_var;
  logic          last_val;
  int            tests = 0;
  int            fails = 0;
  bit            mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic lanes_t pack4(input int a, input int b, input int c, input int d);
    lanes_t r;
    r[0] = VW'(a); r[1] = VW'(b); r[2] = VW'(c); r[3] = VW'(d);
    return r;
  endfunction

  // A batch is a sequence of (var,val) claims; the first claim on a variable
  // fixes its value, a repeat is redundant, a contradicting one is a conflict.
  task automatic model_batch();
    bit    seen [logic [VW-1:0]];
    impl_t surv[$];
    bit    cf = 1'b0;
`ifdef IMPLQ_QUEUE_CHECK_EN
    foreach (mq[k]) seen[mq[k].v] = mq[k].b;
`endif
    for (int j = 0; j < NE; j++) begin
      if (in_valid[j]) begin
        if (seen.exists(in_var[j])) begin
          if (seen[in_var[j]] != in_val[j]) begin
            cf = 1'b1;
            m_cvar = in_var[j];
            break;
          end
        end else begin
          seen[in_var[j]] = in_val[j];
          surv.push_back('{v: in_var[j], b: in_val[j]});
        end
      end
    end
    if (cf) m_conf = 1'b1;
    else foreach (surv[k]) mq.push_back(surv[k]);
  endtask

  // Model update at each rising edge using the inputs held since the negedge.
  initial begin
    forever begin
      @(posedge clock);
      if (!reset_n) begin
        mq.delete();
        m_conf = 1'b0;
        m_cvar = '0;
        last_var = '0;
        last_val = 1'b0;
      end else begin
        bit rdy;
        bit ov;
        rdy = !m_conf && (DEPTH - mq.size() >= NE);
        ov  = !m_conf && (mq.size() > 0);
        if (flush) begin
          mq.delete();
          m_conf = 1'b0;
        end else begin
          if (rdy && (|in_valid)) model_batch();
          if (ov && out_ready) void'(mq.pop_front());
        end
      end
    end
  end

  // Monitor: compares DUT outputs with the model away from the clock edge.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (mon_en) begin
        chk("out_valid", 64'(out_valid), 64'(!m_conf && mq.size() > 0));
        chk("count", 64'(count), 64'(mq.size()));
        chk("empty", 64'(empty), 64'(mq.size() == 0));
        chk("in_ready", 64'(in_ready), 64'(!m_conf && (DEPTH - mq.size() >= NE)));
        chk("conflict", 64'(conflict), 64'(m_conf));
        if (m_conf) chk("conflict_var", 64'(conflict_var), 64'(m_cvar));
        if (mq.size() > 0) begin
          chk("head_var", 64'(out_var), 64'(mq[0].v));
          chk("head_val", 64'(out_val), 64'(mq[0].b));
          last_var = mq[0].v;
          last_val = mq[0].b;
        end else begin
          chk("hold_var", 64'(out_var), 64'(last_var));
          chk("hold_val", 64'(out_val), 64'(last_val));
        end
      end
    end
  end

  task automatic drive(input logic [NE-1:0] v, input lanes_t vars, input logic [NE-1:0] vals,
                       input logic rdy, input logic fl);
    @(negedge clock);
    in_valid  = v;
    in_var    = vars;
    in_val    = vals;
    out_ready = rdy;
    flush     = fl;
  endtask

  task automatic idle(input logic rdy);
    drive('0, '0, '0, rdy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) idle(1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    #3;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst empty", 64'(empty), 64'd1);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst count", 64'(count), 64'd0);
    chk("rst conflict", 64'(conflict), 64'd0);

    // Sparse batch, then in-order drain.
    drive(4'b1011, pack4(5, 9, 0, 12), 4'b1001, 1'b0, 1'b0);
    idle(1'b0);
    #3 chk("A count", 64'(count), 64'd3);
    idle(1'b1);
    #3 chk("A pop0 var", 64'(out_var), 64'd5);
    idle(1'b1);
    #3 chk("A pop1 var", 64'(out_var), 64'd9);
    idle(1'b1);
    #3 chk("A pop2 var", 64'(out_var), 64'd12);
    idle(1'b0);
    #3 chk("A empty", 64'(empty), 64'd1);

    // Intra-batch duplicates.
    drive(4'b1111, pack4(7, 7, 3, 7), 4'b1011, 1'b0, 1'b0);
    idle(1'b0);
    #3 chk("B count", 64'(count), 64'd2);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    // Intra-batch conflict, ignored input while stuck, then flush.
    drive(4'b0101, pack4(4, 0, 4, 0), 4'b0001, 1'b0, 1'b0);
    idle(1'b0);
    #3;
    chk("C conflict", 64'(conflict), 64'd1);
    chk("C conflict_var", 64'(conflict_var), 64'd4);
    chk("C in_ready", 64'(in_ready), 64'd0);
    chk("C out_valid", 64'(out_valid), 64'd0);
    drive(4'b0001, pack4(50, 0, 0, 0), 4'b0001, 1'b1, 1'b0);
    idle(1'b0);
    #3 chk("C ignored count", 64'(count), 64'd0);
    drive('0, '0, '0, 1'b0, 1'b1);
    idle(1'b0);
    #3;
    chk("C flush conflict", 64'(conflict), 64'd0);
    chk("C flush in_ready", 64'(in_ready), 64'd1);

    // Fill to 13, refused batch, pop one, push across the wrap, drain.
    drive(4'b1111, pack4(100, 101, 102, 103), 4'b0101, 1'b0, 1'b0);
    drive(4'b1111, pack4(104, 105, 106, 107), 4'b1100, 1'b0, 1'b0);
    drive(4'b1111, pack4(108, 109, 110, 111), 4'b0011, 1'b0, 1'b0);
    drive(4'b0001, pack4(112, 0, 0, 0), 4'b0001, 1'b0, 1'b0);
    idle(1'b0);
    #3;
    chk("D count13", 64'(count), 64'd13);
    chk("D in_ready full", 64'(in_ready), 64'd0);
    drive(4'b0001, pack4(120, 0, 0, 0), 4'b0001, 1'b0, 1'b0);
    idle(1'b0);
    #3 chk("D refused count", 64'(count), 64'd13);
    idle(1'b1);
    idle(1'b0);
    #3;
    chk("D count12", 64'(count), 64'd12);
    chk("D in_ready again", 64'(in_ready), 64'd1);
    drive(4'b1111, pack4(113, 114, 115, 116), 4'b1010, 1'b0, 1'b0);
    idle(1'b0);
    #3 chk("D count16", 64'(count), 64'd16);
    chk("D head after wrap", 64'(out_var), 64'd101);
    repeat (16) idle(1'b1);
    idle(1'b0);
    #3 chk("D drained", 64'(empty), 64'd1);

`ifdef IMPLQ_QUEUE_CHECK_EN
    // Resident-entry dedupe and conflict.
    drive(4'b0001, pack4(20, 0, 0, 0), 4'b0001, 1'b0, 1'b0);
    idle(1'b0);
    drive(4'b0010, pack4(0, 20, 0, 0), 4'b0010, 1'b0, 1'b0);
    idle(1'b0);
    #3 chk("E dedupe count", 64'(count), 64'd1);
    drive(4'b0001, pack4(20, 0, 0, 0), 4'b0000, 1'b0, 1'b0);
    idle(1'b0);
    #3;
    chk("E conflict", 64'(conflict), 64'd1);
    chk("E conflict_var", 64'(conflict_var), 64'd20);
    drive('0, '0, '0, 1'b0, 1'b1);
    idle(1'b0);
`endif

    // Randomized traffic with small variable range to provoke collisions.
    for (int c = 0; c < 600; c++) begin
      lanes_t vv;
      logic   fl;
      for (int j = 0; j < NE; j++) vv[j] = VW'($urandom_range(0, 7));
      fl = m_conf ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 40) == 0);
      drive(NE'($urandom), vv, NE'($urandom), 1'($urandom_range(0, 3) != 0), fl);
      if (c == 300) begin
        // Asynchronous reset in the middle of traffic.
        #1;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        repeat (2) idle(1'b0);
        reset_n = 1'b1;
        #3 chk("mid reset count", 64'(count), 64'd0);
        chk("mid reset conflict", 64'(conflict), 64'd0);
        mon_en = 1'b1;
      end
    end
    idle(1'b0);
    @(negedge clock);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
